// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: SPI-to-register-bank access controller with write CRC recheck.
// Outputs are registered off the next state so every strobe lines up with the state that owns it.
module crc16to8_parallel (
    input  logic [15:0] data,
    output logic [7:0]  crc
);
    always_comb begin
        crc = '0;
        for (int i = 15; i >= 0; i--)
            crc = {crc[6:0], 1'b0} ^ ((crc[7] ^ data[i]) ? 8'h07 : 8'h00);
    end
endmodule

module reg_access_ctrl #(
    parameter int REG_AW = 7,
    parameter int REG_DW = 8,
    parameter int REG_CRC_W = 8,
    parameter int REG_NUM = 96,
    parameter logic [REG_DW-1:0] ILL_RDATA = 8'hFF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_spi_rac_wr_req,
    input  logic                 i_spi_rac_rd_req,
    input  logic [REG_AW-1:0]    i_spi_rac_addr,
    input  logic [REG_DW-1:0]    i_spi_rac_wdata,
    input  logic [REG_CRC_W-1:0] i_spi_rac_wcrc,
    output logic                 o_rac_spi_wack,
    output logic                 o_rac_spi_rack,
    output logic [REG_DW-1:0]    o_rac_spi_data,
    output logic [REG_AW-1:0]    o_rac_spi_addr,
    output logic                 o_rac_reg_wen,
    output logic                 o_rac_reg_ren,
    output logic [REG_AW-1:0]    o_rac_reg_addr,
    output logic [REG_DW-1:0]    o_rac_reg_wdata,
    input  logic [REG_DW-1:0]    i_reg_rac_rdata,
    output logic                 o_rac_wcrc_err,
    output logic                 o_rac_addr_err,
    output logic                 o_rac_busy
);
    localparam logic [2:0] IDLE = 3'd0, WCHK = 3'd1, WR = 3'd2, RD = 3'd3, RDW = 3'd4, ACK = 3'd5;
    localparam logic [REG_AW-1:0] NUM = REG_AW'(REG_NUM);

    logic [2:0]           state, nxt;
    logic [REG_CRC_W-1:0] wcrc_q, crc;
    logic                 is_wr, guard, ill, ill_in, crc_bad, start;

    crc16to8_parallel u_crc (.data({1'b1, o_rac_reg_addr, o_rac_reg_wdata}), .crc(crc));

    assign ill     = o_rac_reg_addr >= NUM;
    assign ill_in  = (state == IDLE ? i_spi_rac_addr : o_rac_reg_addr) >= NUM;
    assign crc_bad = crc != wcrc_q;
    assign start   = state == IDLE && !guard && (i_spi_rac_wr_req || i_spi_rac_rd_req);

    // Illegal write addresses fall through RD so the read-path error handling is shared.
    always_comb begin
        nxt = state == IDLE ? (guard ? IDLE : i_spi_rac_wr_req ? WCHK : i_spi_rac_rd_req ? RD : IDLE)
            : state == WCHK ? ((ill || crc_bad) ? RD : WR)
            : state == WR   ? RD
            : state == RD   ? (ill ? ACK : RDW)
            : state == RDW  ? ACK
            : IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            guard           <= 1'b0;
            is_wr           <= 1'b0;
            wcrc_q          <= '0;
            o_rac_reg_addr  <= '0;
            o_rac_reg_wdata <= '0;
            o_rac_reg_wen   <= 1'b0;
            o_rac_reg_ren   <= 1'b0;
            o_rac_spi_wack  <= 1'b0;
            o_rac_spi_rack  <= 1'b0;
            o_rac_spi_data  <= '0;
            o_rac_spi_addr  <= '0;
            o_rac_wcrc_err  <= 1'b0;
            o_rac_addr_err  <= 1'b0;
            o_rac_busy      <= 1'b0;
        end else begin
            state          <= nxt;
            guard          <= state == ACK;
            o_rac_reg_wen  <= nxt == WR;
            o_rac_reg_ren  <= nxt == RD && !ill_in;
            o_rac_spi_wack <= nxt == ACK && is_wr;
            o_rac_spi_rack <= nxt == ACK && !is_wr;
            o_rac_wcrc_err <= state == WCHK && !ill && crc_bad;
            o_rac_addr_err <= state == RD && ill;
            o_rac_busy     <= nxt != IDLE;
            if (start) begin
                o_rac_reg_addr  <= i_spi_rac_addr;
                o_rac_reg_wdata <= i_spi_rac_wdata;
                wcrc_q          <= i_spi_rac_wcrc;
                is_wr           <= i_spi_rac_wr_req;
            end
            if (nxt == ACK) begin
                o_rac_spi_addr <= o_rac_reg_addr;
                o_rac_spi_data <= state == RDW ? i_reg_rac_rdata : ILL_RDATA;
            end
        end
    end
endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb_reg_access_ctrl: directed checks of reg_access_ctrl against a behavioural register bank.
module tb_reg_access_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       wr_req = 1'b0, rd_req = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] wdata = '0, wcrc = '0;
    logic       wack, rack, wen, ren, cerr, aerr, busy;
    logic [7:0] spi_data, reg_wdata;
    logic [7:0] rdata = '0;
    logic [6:0] spi_addr, reg_addr;
    logic [7:0] bank [96];
    int total = 0, bad = 0;
    int t_wen, t_ren, t_ack, n_wen, n_ren, n_cerr, n_aerr, extra;
    logic got_wack, got_rack;
    logic [7:0] sd;
    logic [6:0] sa;

    always #5 clk = ~clk;

    reg_access_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_spi_rac_wr_req(wr_req), .i_spi_rac_rd_req(rd_req),
        .i_spi_rac_addr(addr), .i_spi_rac_wdata(wdata), .i_spi_rac_wcrc(wcrc),
        .o_rac_spi_wack(wack), .o_rac_spi_rack(rack),
        .o_rac_spi_data(spi_data), .o_rac_spi_addr(spi_addr),
        .o_rac_reg_wen(wen), .o_rac_reg_ren(ren),
        .o_rac_reg_addr(reg_addr), .o_rac_reg_wdata(reg_wdata),
        .i_reg_rac_rdata(rdata),
        .o_rac_wcrc_err(cerr), .o_rac_addr_err(aerr), .o_rac_busy(busy)
    );

    always @(posedge clk) begin
        if (wen && reg_addr < 7'd96) bank[reg_addr] <= reg_wdata;
        if (ren) rdata <= (reg_addr < 7'd96) ? bank[reg_addr] : 8'h00;
    end

    // CRC-8 (x^8+x^2+x+1, init 0) as polynomial long division of the message times x^8.
    function automatic logic [7:0] gold(input logic [6:0] a, input logic [7:0] d);
        logic [23:0] r;
        r = {1'b1, a, d, 8'h00};
        for (int i = 23; i >= 8; i--)
            if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
        return r[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic wr, input logic rd, input logic [6:0] a, input logic [7:0] d, input logic [7:0] c);
        t_wen = -1; t_ren = -1; t_ack = -1; n_wen = 0; n_ren = 0; n_cerr = 0; n_aerr = 0; extra = 0;
        got_wack = 0; got_rack = 0;
        @(negedge clk);
        wr_req = wr; rd_req = rd; addr = a; wdata = d; wcrc = c;
        for (int k = 1; k <= 12 && t_ack < 0; k++) begin
            @(negedge clk);
            if (wen) begin n_wen++; if (t_wen < 0) t_wen = k; end
            if (ren) begin n_ren++; if (t_ren < 0) t_ren = k; end
            if (cerr) n_cerr++;
            if (aerr) n_aerr++;
            if (wack || rack) begin
                t_ack = k; got_wack = wack; got_rack = rack; sd = spi_data; sa = spi_addr;
                wr_req = 0; rd_req = 0;
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (wack || rack || wen || ren) extra++;
        end
        chk("ack_seen", t_ack >= 0, 1);
        chk("no_extra_activity", extra, 0);
    endtask

    initial begin
        for (int i = 0; i < 96; i++) bank[i] = 8'h00;
        bank[5] = 8'h3C;
        bank[95] = 8'h5A;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {wack, rack, spi_data, spi_addr, wen, ren, reg_addr, reg_wdata, cerr, aerr, busy}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        run(0, 1, 7'h05, 8'h00, 8'h00);
        chk("rd_t_ren", t_ren, 1);
        chk("rd_t_ack", t_ack, 3);
        chk("rd_rack", {got_wack, got_rack}, 2'b01);
        chk("rd_data", sd, 8'h3C);
        chk("rd_addr", sa, 7'h05);
        chk("rd_errs", n_cerr + n_aerr + n_wen, 0);
        chk("rd_hold_data", spi_data, 8'h3C);

        run(0, 1, 7'h5F, 8'h00, 8'h00);
        chk("rd95_t_ack", t_ack, 3);
        chk("rd95_data", sd, 8'h5A);
        chk("rd95_aerr", n_aerr, 0);

        run(1, 0, 7'h10, 8'hA5, gold(7'h10, 8'hA5) ^ 8'h01);
        chk("bad_cerr", n_cerr, 1);
        chk("bad_no_wen", n_wen, 0);
        chk("bad_t_ren", t_ren, 2);
        chk("bad_t_ack", t_ack, 4);
        chk("bad_wack", {got_wack, got_rack}, 2'b10);
        chk("bad_data", sd, 8'h00);
        chk("bad_bank", bank[16], 8'h00);

        run(1, 0, 7'h10, 8'hA5, gold(7'h10, 8'hA5));
        chk("wr_t_wen", t_wen, 2);
        chk("wr_n_wen", n_wen, 1);
        chk("wr_t_ren", t_ren, 3);
        chk("wr_t_ack", t_ack, 5);
        chk("wr_wack", {got_wack, got_rack}, 2'b10);
        chk("wr_data", sd, 8'hA5);
        chk("wr_addr", sa, 7'h10);
        chk("wr_bank", bank[16], 8'hA5);
        chk("wr_no_err", n_cerr + n_aerr, 0);

        run(0, 1, 7'h7F, 8'h00, 8'h00);
        chk("ill_rd_aerr", n_aerr, 1);
        chk("ill_rd_no_ren", n_ren, 0);
        chk("ill_rd_t_ack", t_ack, 2);
        chk("ill_rd_rack", {got_wack, got_rack}, 2'b01);
        chk("ill_rd_data", sd, 8'hFF);
        chk("ill_rd_addr", sa, 7'h7F);

        run(1, 0, 7'h60, 8'h33, 8'h00);
        chk("ill_wr_aerr", n_aerr, 1);
        chk("ill_wr_no_cerr", n_cerr, 0);
        chk("ill_wr_no_strobe", n_wen + n_ren, 0);
        chk("ill_wr_t_ack", t_ack, 3);
        chk("ill_wr_wack", {got_wack, got_rack}, 2'b10);
        chk("ill_wr_data", sd, 8'hFF);
        chk("ill_wr_addr", sa, 7'h60);

        begin
            int nw, nr, tw, tr;
            nw = 0; nr = 0; tw = -1; tr = -1; sd = '0;
            @(negedge clk);
            wr_req = 1; rd_req = 1; addr = 7'h02; wdata = 8'h11; wcrc = gold(7'h02, 8'h11);
            for (int k = 1; k <= 25 && tr < 0; k++) begin
                @(negedge clk);
                if (wack) begin nw++; tw = k; wr_req = 0; end
                if (rack) begin nr++; tr = k; sd = spi_data; rd_req = 0; end
            end
            repeat (4) begin
                @(negedge clk);
                if (wack) nw++;
                if (rack) nr++;
            end
            chk("sim_n_wack", nw, 1);
            chk("sim_n_rack", nr, 1);
            chk("sim_order", tw >= 0 && tr > tw, 1);
            chk("sim_rack_data", sd, 8'h11);
        end

        begin
            int n;
            n = 0;
            @(negedge clk);
            wr_req = 1; addr = 7'h20; wdata = 8'h77; wcrc = gold(7'h20, 8'h77);
            @(negedge clk);
            chk("rst_busy_before", busy, 1);
            rst_n = 1'b0;
            #1;
            chk("rst_outputs", {wack, rack, spi_data, spi_addr, wen, ren, reg_addr, reg_wdata, cerr, aerr, busy}, 0);
            repeat (2) begin @(negedge clk); if (wen) n++; end
            wr_req = 0;
            rst_n = 1'b1;
            repeat (6) begin @(negedge clk); if (wen) n++; end
            chk("rst_no_wen", n, 0);
            chk("rst_busy_after", busy, 0);
            chk("rst_bank", bank[32], 8'h00);
        end

        run(0, 1, 7'h05, 8'h00, 8'h00);
        chk("post_rst_t_ack", t_ack, 3);
        chk("post_rst_data", sd, 8'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
